// File: rtl/runner_pkg.sv
// Shared types, glyph constants and helpers for the side-scrolling runner game.
package runner_pkg;

  typedef enum logic [1:0] {StReady, StRun, StWin, StLose} state_e;
  typedef enum logic [1:0] {Ground, Barrier, Bird} cell_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Active-low 7-segment glyphs
  localparam logic [7:0] GlyphGround    = 8'h77;
  localparam logic [7:0] GlyphBarrier   = 8'h73;
  localparam logic [7:0] GlyphBird      = 8'h75;
  localparam logic [7:0] GlyphJumpOver  = 8'h10;
  localparam logic [7:0] GlyphUnderBird = 8'h21;
  localparam logic [7:0] GlyphDownRole  = 8'h23;
  localparam logic [7:0] GlyphUpRole    = 8'h14;

  // End-of-game banners for cells 3..0
  localparam logic [31:0] LoseCells = 32'hC7C09286;
  localparam logic [31:0] WinCells  = 32'h827F827F;

  localparam logic [1:0] OverRun  = 2'b00;
  localparam logic [1:0] OverWin  = 2'b01;
  localparam logic [1:0] OverLose = 2'b10;

  function automatic logic [7:0] cell_glyph(cell_e c);
    unique case (c)
      Barrier: cell_glyph = GlyphBarrier;
      Bird:    cell_glyph = GlyphBird;
      default: cell_glyph = GlyphGround;
    endcase
  endfunction

  function automatic logic [7:0] player_glyph(cell_e c1, logic down);
    if (c1 == Barrier && !down) begin
      player_glyph = GlyphJumpOver;
    end else if (c1 == Bird && down) begin
      player_glyph = GlyphUnderBird;
    end else if (down) begin
      player_glyph = GlyphDownRole;
    end else begin
      player_glyph = GlyphUpRole;
    end
  endfunction

  function automatic cell_e entry_cell(logic [1:0] r);
    unique case (r)
      2'b10:   entry_cell = Barrier;
      2'b11:   entry_cell = Bird;
      default: entry_cell = Ground;
    endcase
  endfunction

endpackage

// File: rtl/runner_lfsr.sv
// Free-running 16-bit Fibonacci LFSR feeding obstacle generation.
module runner_lfsr
  import runner_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  output logic [15:0] q
);

  // Taps 16,14,13,11 counted from the output end: bit 0 is tap 16.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      q <= LfsrSeed;
    end else begin
      q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    end
  end

endmodule

// File: rtl/runner_game_core.sv
// Runner game core: step timer, game FSM, scrolling obstacle track and registered display outputs.
module runner_game_core
  import runner_pkg::*;
#(
  parameter int unsigned N_CELLS   = 4,
  parameter int unsigned TICK_DIV  = 12_500_000,
  parameter int unsigned LIVES     = 2,
  parameter int unsigned WIN_STEPS = 30
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Up_Down,
  input  logic                 Stop,
  input  logic                 Hard,
  output logic [8*N_CELLS-1:0] Map,
  output logic [LIVES-1:0]     Lives,
  output logic [2:0]           Progress,
  output logic [1:0]           Over
);

  localparam int unsigned MapW   = 8 * N_CELLS;
  localparam int unsigned TimerW = $clog2(TICK_DIV);
  localparam int unsigned LivesW = $clog2(LIVES + 1);
  localparam int unsigned CntW   = $clog2(WIN_STEPS + 1);

  localparam logic [TimerW-1:0] LastFull  = TimerW'(TICK_DIV - 1);
  localparam logic [TimerW-1:0] LastHard  = TimerW'(TICK_DIV / 2 - 1);
  localparam logic [LivesW-1:0] LivesInit = LivesW'(LIVES);
  localparam logic [CntW-1:0]   CntWin    = CntW'(WIN_STEPS);
  localparam logic [CntW-1:0]   CntQ1     = CntW'(WIN_STEPS / 4);
  localparam logic [CntW-1:0]   CntQ2     = CntW'(WIN_STEPS / 2);
  localparam logic [CntW-1:0]   CntQ3     = CntW'(3 * WIN_STEPS / 4);

  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  runner_lfsr u_lfsr (
    .clk   (clk),
    .Reset (Reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:2];

  // Step timer; >= lets a mid-count switch to Hard fire immediately
  logic [TimerW-1:0] timer_q, timer_d;
  logic              step;

  always_comb begin
    step    = !Stop && (timer_q >= (Hard ? LastHard : LastFull));
    timer_d = timer_q;
    if (step) begin
      timer_d = '0;
    end else if (!Stop) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  // Game state
  state_e            state_q, state_d;
  cell_e             track_q [N_CELLS-1:1];
  cell_e             track_d [N_CELLS-1:1];
  logic [LivesW-1:0] lives_q, lives_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              hit;

  assign hit = (track_q[1] == Barrier && Up_Down) || (track_q[1] == Bird && !Up_Down);

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (step) begin
      unique case (state_q)
        StReady: state_d = StRun;
        StRun: begin
          if (hit) begin
            lives_d = lives_q - LivesW'(1);
          end
          cnt_d = cnt_q + CntW'(1);
          for (int unsigned k = 1; k < N_CELLS - 1; k++) begin
            track_d[k] = track_q[k+1];
          end
          // Never two obstacles back to back, so every one is dodgeable
          track_d[N_CELLS-1] = (track_q[N_CELLS-1] != Ground) ? Ground : entry_cell(lfsr_q[1:0]);
          if (lives_d == '0) begin
            state_d = StLose;
          end else if (cnt_d >= CntWin) begin
            state_d = StWin;
          end
        end
        default: ;
      endcase
    end
  end

  // Output next-state, built from next game state so effects land one clk after the step
  logic [MapW-1:0]  map_d;
  logic [LIVES-1:0] lives_th_d;
  logic [2:0]       prog_d;
  logic [1:0]       over_d;

  always_comb begin
    map_d      = '1;
    lives_th_d = '0;
    prog_d     = '0;
    over_d     = OverRun;
    unique case (state_d)
      StLose: begin
        map_d[31:0] = LoseCells;
        over_d      = OverLose;
      end
      StWin: begin
        map_d[31:0] = WinCells;
        over_d      = OverWin;
      end
      default: begin
        map_d[7:0] = player_glyph(track_d[1], Up_Down);
        for (int unsigned k = 1; k < N_CELLS; k++) begin
          map_d[8*k +: 8] = cell_glyph(track_d[k]);
        end
        for (int unsigned i = 0; i < LIVES; i++) begin
          lives_th_d[i] = lives_d > LivesW'(i);
        end
        prog_d = {cnt_d >= CntQ3, cnt_d >= CntQ2, cnt_d >= CntQ1};
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      timer_q  <= '0;
      state_q  <= StReady;
      lives_q  <= LivesInit;
      cnt_q    <= '0;
      for (int unsigned k = 1; k < N_CELLS; k++) begin
        track_q[k] <= Ground;
      end
      Map      <= {{(N_CELLS - 1){GlyphGround}}, GlyphDownRole};
      Lives    <= '1;
      Progress <= '0;
      Over     <= OverRun;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      track_q <= track_d;
      // Display freezes with the game while paused
      if (!Stop) begin
        Map      <= map_d;
        Lives    <= lives_th_d;
        Progress <= prog_d;
        Over     <= over_d;
      end
    end
  end

endmodule

// File: tb/tb_runner_game_core.sv
// Scoreboard bench for runner_game_core: driver models each cycle and queues expectations, monitor checks.
module tb_runner_game_core;

  localparam int NC = 4;
  localparam int TD = 4;
  localparam int NL = 2;
  localparam int WS = 8;

  logic            clk = 1'b0;
  logic            Reset, Up_Down, Stop, Hard;
  logic [8*NC-1:0] Map;
  logic [NL-1:0]   Lives;
  logic [2:0]      Progress;
  logic [1:0]      Over;

  runner_game_core #(
    .N_CELLS   (NC),
    .TICK_DIV  (TD),
    .LIVES     (NL),
    .WIN_STEPS (WS)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Up_Down  (Up_Down),
    .Stop     (Stop),
    .Hard     (Hard),
    .Map      (Map),
    .Lives    (Lives),
    .Progress (Progress),
    .Over     (Over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] map;
    logic [1:0]  lives;
    logic [2:0]  prog;
    logic [1:0]  over;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: taps 16,14,13,11, bit 0 is the output end
  logic [15:0] tb_lfsr;
  always @(posedge clk or negedge Reset) begin
    if (!Reset) tb_lfsr <= 16'hACE1;
    else        tb_lfsr <= {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
  end

  // Model: state 0 ready, 1 run, 2 win, 3 lose; cell 0 ground, 1 barrier, 2 bird
  int   m_state, m_lives, m_cnt, m_timer;
  int   m_c[NC];
  exp_t m_out;
  int   steps_run = 0;
  int   bar_hits = 0;

  function automatic logic [7:0] tglyph(int c);
    if (c == 1) return 8'h73;
    if (c == 2) return 8'h75;
    return 8'h77;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = NL; m_cnt = 0; m_timer = 0;
    for (int k = 0; k < NC; k++) m_c[k] = 0;
    m_out.map = 32'h77777723; m_out.lives = 2'b11; m_out.prog = 3'b000; m_out.over = 2'b00;
  endtask

  task automatic render(input logic ud);
    if (m_state == 3) begin
      m_out.map = 32'hC7C09286; m_out.lives = '0; m_out.prog = '0; m_out.over = 2'b10;
    end else if (m_state == 2) begin
      m_out.map = 32'h827F827F; m_out.lives = '0; m_out.prog = '0; m_out.over = 2'b01;
    end else begin
      for (int k = 1; k < NC; k++) m_out.map[8*k +: 8] = tglyph(m_c[k]);
      if (m_c[1] == 1 && !ud)      m_out.map[7:0] = 8'h10;
      else if (m_c[1] == 2 && ud)  m_out.map[7:0] = 8'h21;
      else if (ud)                 m_out.map[7:0] = 8'h23;
      else                         m_out.map[7:0] = 8'h14;
      m_out.lives = NL'((1 << m_lives) - 1);
      m_out.prog  = {m_cnt >= 3 * WS / 4, m_cnt >= WS / 2, m_cnt >= WS / 4};
      m_out.over  = 2'b00;
    end
  endtask

  task automatic model_step(input logic ud);
    int prev;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if ((m_c[1] == 1 && ud) || (m_c[1] == 2 && !ud)) begin
        m_lives--;
        if (m_c[1] == 1) bar_hits++;
      end
      m_cnt++;
      steps_run++;
      prev = m_c[NC-1];
      for (int k = 1; k < NC - 1; k++) m_c[k] = m_c[k+1];
      if (prev != 0)                   m_c[NC-1] = 0;
      else if (tb_lfsr[1:0] == 2'b10)  m_c[NC-1] = 1;
      else if (tb_lfsr[1:0] == 2'b11)  m_c[NC-1] = 2;
      else                             m_c[NC-1] = 0;
      if (m_lives == 0)    m_state = 3;
      else if (m_cnt >= WS) m_state = 2;
    end
  endtask

  // Called at a negedge: drive inputs for the coming posedge, predict, queue, advance
  task automatic cycle(input logic ud, input logic st, input logic hd, input string tag);
    exp_t e;
    int   per;
    Up_Down = ud; Stop = st; Hard = hd;
    if (!st) begin
      per = hd ? TD / 2 : TD;
      if (m_timer >= per - 1) begin
        m_timer = 0;
        model_step(ud);
      end else begin
        m_timer++;
      end
      render(ud);
    end
    e = m_out; e.due = cyc + 1; e.tag = tag;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input int pre_stop, input logic hd);
    exp_t e;
    #2;
    Reset = 1'b0;
    model_reset();
    e = m_out; e.due = cyc; e.tag = "reset";
    sbq.push_back(e);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < pre_stop; i++) cycle(1'b1, 1'b1, hd, "prestop");
  endtask

  // mode 0 dodge everything, 1 take one barrier hit then dodge, 2 always up
  function automatic logic pick_ud(input int mode, input logic hd);
    int per;
    per = hd ? TD / 2 : TD;
    if (mode == 2) return 1'b0;
    if (mode == 1 && m_c[1] == 1 && bar_hits == 0) return logic'(m_timer >= per - 1);
    return logic'(m_c[1] == 2);
  endfunction

  task automatic play(input int mode, input logic hd, input string tag);
    for (int i = 0; i < 400 && m_state < 2; i++) cycle(pick_ud(mode, hd), 1'b0, hd, tag);
    for (int i = 0; i < 3; i++) cycle(i[0], 1'b0, hd, {tag, "_hold"});
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge Reset);
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        n_cmp++;
        if (Map !== e.map || Lives !== e.lives || Progress !== e.prog || Over !== e.over) begin
          n_bad++;
          $display("FAIL %s cyc %0d: got Map=%h Lives=%b Progress=%b Over=%b, want Map=%h Lives=%b Progress=%b Over=%b",
                   e.tag, cyc, Map, Lives, Progress, Over, e.map, e.lives, e.prog, e.over);
        end
        if (Reset && Over == 2'b00) begin
          for (int k = 1; k < NC - 1; k++) begin
            n_cmp++;
            if (Map[8*k +: 8] != 8'h77 && Map[8*(k+1) +: 8] != 8'h77) begin
              n_bad++;
              $display("FAIL adjacent_obstacles cyc %0d: got Map=%h, want no two adjacent non-ground cells",
                       cyc, Map);
            end
          end
        end
      end
    end
  end

  initial begin
    bit lost;
    Reset = 1'b0; Up_Down = 1'b1; Stop = 1'b0; Hard = 1'b0;
    @(negedge clk);
    do_reset(0, 1'b0);

    // First step at cycle 4 moves READY->RUN with the track untouched
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, "ready");
    play(0, 1'b0, "win");

    // Dodge a barrier (jump glyph) then take one barrier hit
    for (int r = 0; r < 40 && bar_hits == 0; r++) begin
      do_reset(r, 1'b0);
      play(1, 1'b0, "barrier");
    end
    n_cmp++;
    if (bar_hits == 0) begin
      n_bad++;
      $display("FAIL barrier_search: got 0 barrier hits, want at least 1");
    end

    // Stay up: birds drain both lives
    lost = 1'b0;
    for (int r = 0; r < 40 && !lost; r++) begin
      do_reset(r + 1, 1'b0);
      play(2, 1'b0, "lose");
      lost = (m_state == 3);
    end
    n_cmp++;
    if (!lost) begin
      n_bad++;
      $display("FAIL lose_search: got no loss, want a loss");
    end
    do_reset(0, 1'b0);

    // Pause mid-run, then resume in hard mode
    for (int i = 0; i < 10; i++) cycle(pick_ud(0, 1'b0), 1'b0, 1'b0, "run");
    Up_Down = pick_ud(0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(Up_Down, 1'b1, 1'b0, "stopped");
    play(0, 1'b1, "hard");

    // Long soak over many games in hard mode
    steps_run = 0;
    for (int g = 0; g < 300 && steps_run < 1000; g++) begin
      do_reset(g % 11, 1'b1);
      play(0, 1'b1, "soak");
    end
    n_cmp++;
    if (steps_run < 1000) begin
      n_bad++;
      $display("FAIL soak_length: got %0d steps, want 1000", steps_run);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/runner_game_core.md
RUNNER_GAME_CORE -- requirements
Module: runner_game_core

Interface
REQ-001 SHALL have parameter N_CELLS, default 4, track length in 7-segment cells (4..8).
REQ-002 SHALL have parameter TICK_DIV, default 12_500_000, clk cycles per scroll step in normal mode (>=4, even).
REQ-003 SHALL have parameter LIVES, default 2, collisions tolerated before loss (1..3).
REQ-004 SHALL have parameter WIN_STEPS, default 30, scroll steps survived to win (>=4).
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port Up_Down  input  1  posture: 1 = down/duck, 0 = up/jump.
REQ-008 SHALL have port Stop  input  1  pause: freezes the step timer and FSM.
REQ-009 SHALL have port Hard  input  1  hard mode: step period TICK_DIV/2.
REQ-010 SHALL have port Map  output  8*N_CELLS  active-low segment glyphs; cell 0 (bits 7:0) is the player cell, cell N_CELLS-1 is entry.
REQ-011 SHALL have port Lives  output  LIVES  thermometer of remaining lives.
REQ-012 SHALL have port Progress  output  3  thermometer of step count.
REQ-013 SHALL have port Over  output  2  00 running/ready, 01 win, 10 lose.

Function
REQ-014 Step timer SHALL count clk cycles to period-1 (period = Hard ? TICK_DIV/2 : TICK_DIV), then pulse step for one cycle and restart; it SHALL use >= compare so a mid-count Hard change fires at once.
REQ-015 While Stop=1 the timer, FSM, track, and counters SHALL hold; the LFSR SHALL keep running.
REQ-016 FSM states SHALL be READY, RUN, WIN, LOSE; READY->RUN on first step (no shift); RUN->LOSE or RUN->WIN per REQ-020/021; WIN and LOSE SHALL be terminal until Reset.
REQ-017 On each RUN step, collision SHALL be evaluated on cell 1 and sampled Up_Down: BARRIER with Up_Down=1, or BIRD with Up_Down=0, is a hit.
REQ-018 On each RUN step the track SHALL shift toward the player (cell k <= cell k+1, k>=1); the entry cell SHALL load from LFSR[1:0]: 00/01 GROUND, 10 BARRIER, 11 BIRD; if the previous entry was not GROUND, GROUND SHALL be forced.
REQ-019 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advancing every clk.
REQ-020 A hit SHALL decrement lives; lives reaching 0 SHALL enter LOSE on that step.
REQ-021 Step count SHALL increment each RUN step; reaching WIN_STEPS with lives>0 SHALL enter WIN; a hit to 0 lives on the same step SHALL take priority (LOSE).
REQ-022 Player glyph: cell1 BARRIER and Up -> JUMP_OVER 8'h10; cell1 BIRD and Down -> UNDER_BIRD 8'h21; otherwise Down -> DOWN_ROLE 8'h23, Up -> UP_ROLE 8'h14; track glyphs GROUND 8'h77, BARRIER 8'h73, BIRD 8'h75.
REQ-023 Progress[0],[1],[2] SHALL set when count >= WIN_STEPS/4, /2, 3*WIN_STEPS/4 (integer division).
REQ-024 In LOSE, cells 3..0 SHALL show C7,C0,92,86; in WIN, 82,7F,82,7F; higher cells 8'hFF; Lives and Progress SHALL be 0.
REQ-025 All outputs SHALL be registered; step effects SHALL appear one clk after the step pulse.

Reset
REQ-026 Reset low SHALL immediately force READY, all cells GROUND except cell 0 DOWN_ROLE, Lives all ones, Progress 0, Over 00, timer 0, step count 0, LFSR seed.
REQ-027 Reset asserted mid-run or in WIN/LOSE SHALL behave identically to power-up reset.

Structure
REQ-028 Package runner_pkg SHALL hold glyph constants, the FSM state enum, and the cell-type enum (GROUND, BARRIER, BIRD).
REQ-029 The LFSR SHALL be sub-module runner_lfsr (ports clk, Reset, q[15:0]).

Verification (TICK_DIV=4, WIN_STEPS=8, LIVES=2, N_CELLS=4)
REQ-030 Reset release, Hard=0, Stop=0 -> first step at cycle 4, READY->RUN, Map = 77,77,77,23 unchanged.
REQ-031 Force BARRIER into cell 1, Up_Down=0 -> player 8'h10, Lives stays 2'b11; Up_Down=1 -> Lives 2'b01.
REQ-032 Two BIRD hits with Up_Down=0 -> Over=10, Map[31:0]=32'hC7C09286, Lives=0.
REQ-033 Up_Down toggled to dodge every obstacle for 8 steps -> Progress 001/011/111 at steps 2/4/6; Over=01, Map[31:0]=32'h827F827F.
REQ-034 Stop=1 for 20 cycles mid-run -> Map and step count frozen; Hard=1 afterwards -> steps every 2 cycles.
REQ-035 Reset pulsed low in LOSE -> immediate return to REQ-026 values; no two consecutive non-GROUND entries over 1000 steps.
